// File: rtl/etc_pkg.sv
// Shared op codes, FSM state and tile types for the extended tensor core front end.
// Pure declarations; no timing or flow-control behaviour lives here.
// Users import etc_pkg::* and size their own ports from ETC_W or a local W.
package etc_pkg;

    localparam int ETC_W = 16;

    localparam logic [4:0] OP_MULPLUS  = 5'b00000;
    localparam logic [4:0] OP_PLUSPLUS = 5'b00001;
    localparam logic [4:0] OP_MULMIN   = 5'b01000;
    localparam logic [4:0] OP_PLUSMIN  = 5'b01001;
    localparam logic [4:0] OP_MULMAX   = 5'b10000;
    localparam logic [4:0] OP_PLUSMAX  = 5'b10001;
    localparam logic [4:0] OP_L2D      = 5'b00010;
    localparam logic [4:0] OP_MINMAX   = 5'b01011;
    localparam logic [4:0] OP_MAXMIN   = 5'b10100;
    localparam logic [4:0] OP_ORAND    = 5'b11101;

    typedef enum logic [1:0] {LOAD, ISSUE, DRAIN} state_t;

    typedef logic [3:0][ETC_W-1:0] row_t;
    typedef row_t [3:0]            tile_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_MULPLUS, OP_PLUSPLUS, OP_MULMIN, OP_PLUSMIN, OP_MULMAX,
            OP_PLUSMAX, OP_L2D, OP_MINMAX, OP_MAXMIN, OP_ORAND: is_legal_op = 1'b1;
            default:                                            is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/etc_tile_assembler.sv
// Collects 8 operand rows (A rows 0-3, then B rows 0-3) and latches the op on beat 0.
// Latency: a row is visible on tileA/tileB the cycle after its beat is accepted.
// Backpressure: none of its own; the parent gates beatEn with its ready.
module etc_tile_assembler
    import etc_pkg::*;
#(
    parameter int W = ETC_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   beatEn,
    input  logic [3:0][W-1:0]      rowIn,
    input  logic [4:0]             opIn,
    output logic [3:0][3:0][W-1:0] tileA,
    output logic [3:0][3:0][W-1:0] tileB,
    output logic [4:0]             opOut,
    output logic [2:0]             beat,
    output logic                   done
);

    logic [7:0][3:0][W-1:0] rowBuf;

    assign tileA = rowBuf[3:0];
    assign tileB = rowBuf[7:4];
    assign done  = beatEn && (beat == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rowBuf <= '0;
            beat   <= '0;
            opOut  <= '0;
        end else if (beatEn) begin
            rowBuf[beat] <= rowIn;
            beat         <= beat + 3'd1;
            if (beat == 3'd0) opOut <= opIn;
        end
    end

endmodule

// File: rtl/etc_tile_issuer.sv
// Loads an A/B tile, holds it on the core for CORE_LAT cycles, then drains the 4-row result.
// Latency: result row 0 valid CORE_LAT cycles after the last operand beat. Optional ETC_ISSUER_PERF_EN adds counters.
// Backpressure: in_ready only in LOAD; out_row/out_valid hold while out_ready is low.
module etc_tile_issuer
    import etc_pkg::*;
#(
    parameter int W        = ETC_W,
    parameter int CORE_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0][W-1:0]      in_row,
    input  logic [4:0]             in_op,
    output logic [4:0]             core_op,
    output logic [3:0][3:0][W-1:0] core_inA,
    output logic [3:0][3:0][W-1:0] core_inB,
    input  logic [3:0][3:0][W-1:0] core_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0][W-1:0]      out_row,
    output logic                   out_last,
    output logic                   op_err
`ifdef ETC_ISSUER_PERF_EN
    ,
    output logic [31:0]            perf_tiles,
    output logic [31:0]            perf_stall
`endif
);

    localparam logic [3:0] LAST_WAIT = 4'(CORE_LAT - 1);

    state_t                 state;
    logic [3:0]             waitCnt;
    logic [1:0]             rowIdx;
    logic [3:0][3:0][W-1:0] resBuf;
    logic [2:0]             beat;
    logic                   accept;
    logic                   tileDone;

    assign accept = in_valid && in_ready;

    // The operand buffer drives the core directly; it only changes on accepted beats, so it is frozen outside LOAD.
    etc_tile_assembler #(.W(W)) u_assembler (
        .clk    (clk),
        .rst_n  (rst_n),
        .beatEn (accept),
        .rowIn  (in_row),
        .opIn   (in_op),
        .tileA  (core_inA),
        .tileB  (core_inB),
        .opOut  (core_op),
        .beat   (beat),
        .done   (tileDone)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            waitCnt   <= '0;
            rowIdx    <= '0;
            resBuf    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            op_err    <= 1'b0;
        end else begin
            op_err <= accept && (beat == 3'd0) && !is_legal_op(in_op);
            case (state)
                LOAD: begin
                    in_ready <= !tileDone;
                    if (tileDone) begin
                        state   <= ISSUE;
                        waitCnt <= '0;
                    end
                end
                ISSUE: begin
                    if (waitCnt == LAST_WAIT) begin
                        resBuf    <= core_out;
                        out_row   <= core_out[0];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        rowIdx    <= '0;
                        state     <= DRAIN;
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rowIdx == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            rowIdx   <= rowIdx + 2'd1;
                            out_row  <= resBuf[rowIdx + 2'd1];
                            out_last <= (rowIdx == 2'd2);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef ETC_ISSUER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_tiles <= '0;
            perf_stall <= '0;
        end else if (state == DRAIN) begin
            if (out_valid && out_ready && (rowIdx == 2'd3)) perf_tiles <= perf_tiles + 32'd1;
            if (out_valid && !out_ready)                     perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
